// File: rtl/keypad_codes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : keypad_codes
// Description : Key codes shared by the keypad scanner, the calculator FSM
//               and the calculation unit, plus the matrix position to key
//               code decoder.
//               Digits have bit7 = 0, operators have upper nibble 4'hF, and
//               Clear / Equal match neither pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_codes;

   localparam logic [7:0] encout_Clear = 8'hC0;
   localparam logic [7:0] encout_Equ   = 8'hE0;

   localparam logic [7:0] OP_ADD   = 8'hF0;
   localparam logic [7:0] OP_SUB   = 8'hF1;
   localparam logic [7:0] OP_MUL   = 8'hF2;
   localparam logic [7:0] OP_DIV   = 8'hF3;
   localparam logic [7:0] KEY_ZERO = 8'h00;
   localparam logic [7:0] KEY_IDLE = 8'hFF;

   // Matrix position (row r, column c) to key code.
   // Column 3 holds the operators in row order (F0..F3). Row 3 holds
   // Clear, 0, Equal. The remaining 3x3 block holds digits 1..9.
   function automatic logic [7:0] decode_key(input logic [1:0] r, input logic [1:0] c);
      logic [7:0] code;
      if (c == 2'd3) begin
         code = {6'b111100, r};
      end else if (r == 2'd3) begin
         case (c)
            2'd0:    code = encout_Clear;
            2'd1:    code = KEY_ZERO;
            default: code = encout_Equ;
         endcase
      end else begin
         code = ({6'd0, r} * 8'd3) + {6'd0, c} + 8'd1;
      end
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Parameterised-width two-flop synchroniser. Resets to all
//               ones so that pulled-up inputs read as idle during reset.
// Ports       : clk - system clock
//               rst - asynchronous reset, active low
//               d   - asynchronous input bus
//               q   - synchronised output bus
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Scans a 4x4 active-low key matrix one column at a time,
//               synchronises and debounces the rows, and reports a single
//               accepted key as an 8-bit code with a level 'pressed' flag.
//               Multiple simultaneous rows in one column are ignored (no
//               ghost decode); a held key yields exactly one pressed pulse.
// Ports       : clk      - system clock
//               rst      - asynchronous reset, active low
//               row      - matrix rows (async, pulled up, low = closed)
//               col      - matrix column drive, exactly one bit low
//               key_code - accepted key code, 8'hFF when none
//               pressed  - high while a debounced key is held
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
   import keypad_codes::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [7:0] key_code,
   output logic       pressed
);

   // One counter serves both the column dwell and the debounce runs.
   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    pattern;   // row pattern captured at detection
   logic [1:0]    row_idx;
   logic [1:0]    col_idx;

   logic [3:0]    rs;
   logic          single_low;
   logic [1:0]    rs_row;
   logic [1:0]    cur_col;
   logic [3:0]    next_col;
   logic          last_dwell;
   logic          deb_done;

   sync2 #(.WIDTH(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row),
      .q   (rs)
   );

   // Exactly one row low identifies a single key; anything else is
   // either idle or an ambiguous multi-key pattern.
   always_comb begin
      single_low = 1'b1;
      rs_row     = 2'd0;
      case (rs)
         4'b1110: rs_row = 2'd0;
         4'b1101: rs_row = 2'd1;
         4'b1011: rs_row = 2'd2;
         4'b0111: rs_row = 2'd3;
         default: single_low = 1'b0;
      endcase
   end

   always_comb begin
      cur_col = 2'd0;
      case (col)
         4'b1101: cur_col = 2'd1;
         4'b1011: cur_col = 2'd2;
         4'b0111: cur_col = 2'd3;
         default: cur_col = 2'd0;
      endcase
   end

   assign next_col   = {col[2:0], col[3]};
   assign last_dwell = (cnt == CW'(SCAN_DIV - 1));
   // The transition edge is the one on which the count would reach the
   // threshold, so compare against threshold-1 before incrementing.
   assign deb_done   = (cnt == CW'(DEBOUNCE_CNT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_SCAN;
         cnt      <= '0;
         col      <= 4'b1110;
         key_code <= KEY_IDLE;
         pressed  <= 1'b0;
         pattern  <= 4'hF;
         row_idx  <= 2'd0;
         col_idx  <= 2'd0;
      end else begin
         case (state)
            ST_SCAN: begin
               if (last_dwell) begin
                  cnt <= '0;
                  if (single_low) begin
                     pattern <= rs;
                     row_idx <= rs_row;
                     col_idx <= cur_col;
                     state   <= ST_DEBOUNCE;
                  end else begin
                     col <= next_col;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_DEBOUNCE: begin
               if (rs != pattern) begin
                  cnt   <= '0;
                  col   <= next_col;
                  state <= ST_SCAN;
               end else if (deb_done) begin
                  cnt      <= '0;
                  key_code <= decode_key(row_idx, col_idx);
                  pressed  <= 1'b1;
                  state    <= ST_HELD;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_HELD: begin
               // Only an all-high run counts towards release; any closed
               // row in this column (same or extra key) restarts it.
               if (rs == 4'hF) begin
                  if (deb_done) begin
                     cnt     <= '0;
                     pressed <= 1'b0;
                     state   <= ST_RELEASE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  cnt <= '0;
               end
            end

            ST_RELEASE: begin
               key_code <= KEY_IDLE;
               col      <= next_col;
               cnt      <= '0;
               state    <= ST_SCAN;
            end

            default: begin
               state <= ST_SCAN;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner. A physical key
//               matrix is modelled from a 16-bit held-key vector, and a
//               behavioural reference predicts col, key_code and pressed
//               every cycle from elapsed-cycle and stable-run rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;

   localparam int M_SCAN    = 0;
   localparam int M_CONFIRM = 1;
   localparam int M_HOLD    = 2;
   localparam int M_REL     = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] row;
   logic [3:0] col;
   logic [7:0] key_code;
   logic       pressed;

   logic [15:0] held = '0;    // bit r*4+c = key at row r, column c closed
   logic [3:0]  row_s = 4'hF;

   int tests = 0;
   int fails = 0;
   int pulses = 0;
   logic [7:0] last_code = 8'hFF;
   logic       p_prev = 1'b0;

   logic [7:0] keymap [4][4];

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .col      (col),
      .key_code (key_code),
      .pressed  (pressed)
   );

   always #5 clk = ~clk;

   // Passive matrix: a row is pulled low when any closed key on it sits
   // in the column currently driven low.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row[r] = ~(|(held[r*4 +: 4] & ~col));
      end
   end

   // Row value seen at mid-cycle is what the next rising edge samples.
   always @(negedge clk) row_s <= row;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int         m_cyc, m_base, m_det, m_run, m_mode, m_cidx, m_ridx;
   logic [3:0] m_s1, m_s2, m_prev, m_pat, m_smp;
   logic [7:0] e_code;
   logic       e_pressed;

   task automatic model_reset();
      m_cyc = 0; m_base = 0; m_det = 0; m_run = 0;
      m_mode = M_SCAN; m_cidx = 0; m_ridx = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_prev = 4'hF; m_pat = 4'hF;
      e_code = 8'hFF; e_pressed = 1'b0;
   endtask

   task automatic model_step();
      m_smp = m_s2;
      m_cyc++;
      if (m_smp == m_prev) m_run++;
      else m_run = 1;
      m_prev = m_smp;
      case (m_mode)
         M_SCAN: begin
            if (m_cyc - m_base == SCAN_DIV) begin
               if ($countones(~m_smp) == 1) begin
                  m_pat = m_smp;
                  for (int i = 0; i < 4; i++) if (!m_smp[i]) m_ridx = i;
                  m_det  = m_cyc;
                  m_mode = M_CONFIRM;
               end else begin
                  m_cidx = (m_cidx + 1) % 4;
                  m_base = m_cyc;
               end
            end
         end
         M_CONFIRM: begin
            if (m_smp != m_pat) begin
               m_mode = M_SCAN;
               m_cidx = (m_cidx + 1) % 4;
               m_base = m_cyc;
            end else if (m_cyc - m_det == DEB) begin
               m_mode    = M_HOLD;
               e_code    = keymap[m_ridx][m_cidx];
               e_pressed = 1'b1;
            end
         end
         M_HOLD: begin
            if (m_smp == 4'hF && m_run >= DEB) begin
               e_pressed = 1'b0;
               m_mode    = M_REL;
            end
         end
         default: begin
            e_code = 8'hFF;
            m_cidx = (m_cidx + 1) % 4;
            m_base = m_cyc;
            m_mode = M_SCAN;
         end
      endcase
      m_s2 = m_s1;
      m_s1 = row_s;
   endtask

   initial begin
      keymap[0] = '{8'h01, 8'h02, 8'h03, 8'hF0};
      keymap[1] = '{8'h04, 8'h05, 8'h06, 8'hF1};
      keymap[2] = '{8'h07, 8'h08, 8'h09, 8'hF2};
      keymap[3] = '{8'hC0, 8'h00, 8'hE0, 8'hF3};
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) model_reset();
         else model_step();
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      logic [3:0] ecol;
      forever begin
         @(negedge clk);
         ecol = ~(4'b0001 << m_cidx);
         chk("col", {28'd0, col}, {28'd0, ecol});
         chk("key_code", {24'd0, key_code}, {24'd0, e_code});
         chk("pressed", {31'd0, pressed}, {31'd0, e_pressed});
         chk("col_one_low", $countones(~col), 32'd1);
      end
   end

   // Pulse counter: rising edges of pressed and the code seen on each.
   initial begin
      forever begin
         @(negedge clk);
         if (pressed && !p_prev) begin
            pulses++;
            last_code = key_code;
         end
         p_prev = pressed;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ stimulus
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_level(input logic lvl, input int maxc, input string name);
      int k;
      k = 0;
      while (pressed !== lvl && k < maxc) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, pressed}, {31'd0, lvl});
   endtask

   task automatic bounce_to(input logic [15:0] v);
      logic [15:0] old;
      int n;
      old = held;
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
         held = (i % 2 == 0) ? v : old;
         tick($urandom_range(1, 3));
      end
      held = v;
   endtask

   task automatic press_hold_release(input int bitn, input int hold, input string nm,
                                     input logic [7:0] code);
      pulses = 0;
      held = '0;
      held[bitn] = 1'b1;
      tick(hold);
      held = '0;
      wait_level(1'b0, 40, {nm, "_fall"});
      chk({nm, "_pulses"}, pulses, 32'd1);
      chk({nm, "_code"}, {24'd0, last_code}, {24'd0, code});
      tick(20);
   endtask

   initial begin
      logic [15:0] v;
      // Reset and idle scan
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_col", {28'd0, col}, 32'hE);
      chk("rst_code", {24'd0, key_code}, 32'hFF);
      chk("rst_pressed", {31'd0, pressed}, 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_col0", {28'd0, col}, 32'hE);
      end
      @(negedge clk);
      chk("idle_col1", {28'd0, col}, 32'hD);
      tick(30);
      chk("idle_pulses", pulses, 32'd0);

      // Clean press of '5'
      pulses = 0;
      held[5] = 1'b1;
      wait_level(1'b1, 60, "k5_rise");
      chk("k5_code", {24'd0, key_code}, 32'h05);
      chk("k5_col", {28'd0, col}, 32'hD);
      tick(30);
      held = '0;
      wait_level(1'b0, 40, "k5_fall");
      @(negedge clk);
      chk("k5_idle_code", {24'd0, key_code}, 32'hFF);
      chk("k5_pulses", pulses, 32'd1);
      tick(20);

      // Bounce on '='
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         held[14] = ~held[14];
         tick(3);
      end
      chk("eq_bounce_pulses", pulses, 32'd0);
      held[14] = 1'b1;
      tick(40);
      held = '0;
      wait_level(1'b0, 40, "eq_fall");
      chk("eq_pulses", pulses, 32'd1);
      chk("eq_code", {24'd0, last_code}, 32'hE0);
      tick(20);

      // Ghost rejection, then a single key in the same column
      pulses = 0;
      held = '0;
      held[0] = 1'b1;
      held[8] = 1'b1;
      tick(60);
      chk("ghost_pulses", pulses, 32'd0);
      held[8] = 1'b0;
      tick(40);
      held = '0;
      wait_level(1'b0, 40, "k1_fall");
      chk("k1_pulses", pulses, 32'd1);
      chk("k1_code", {24'd0, last_code}, 32'h01);
      tick(20);

      // Operator and Clear with long holds
      press_hold_release(3, 200, "add", 8'hF0);
      press_hold_release(12, 200, "clr", 8'hC0);

      // Reset in the middle of a held '9'
      pulses = 0;
      held[10] = 1'b1;
      wait_level(1'b1, 60, "k9_rise");
      chk("k9_code", {24'd0, key_code}, 32'h09);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("k9_rst_pressed", {31'd0, pressed}, 32'd0);
      chk("k9_rst_code", {24'd0, key_code}, 32'hFF);
      chk("k9_rst_col", {28'd0, col}, 32'hE);
      tick(3);
      rst = 1'b1;
      pulses = 0;
      tick(80);
      chk("k9_again_pulses", pulses, 32'd1);
      chk("k9_again_code", {24'd0, last_code}, 32'h09);
      held = '0;
      wait_level(1'b0, 40, "k9_fall");
      tick(20);

      // Randomised presses, extra keys, bounce and occasional resets
      for (int n = 0; n < 30; n++) begin
         v = '0;
         v[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 15)] = 1'b1;
         bounce_to(v);
         tick($urandom_range(5, 60));
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #2 rst = 1'b0;
            tick($urandom_range(1, 3));
            rst = 1'b1;
         end
         bounce_to('0);
         tick($urandom_range(1, 40));
      end
      tick(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
